riscv_hwloop_regfile: RTL

Register bank and decrement bookkeeping for the RI5CY hardware-loop unit. It holds start address, end address and iteration count for each of N_REGS loops, and accepts setup writes from the ID stage. It tracks end-of-body decrement requests from the hwloop controller while the matching instruction is in flight from IF to ID, and applies each decrement only when that instruction leaves ID. It feeds the controller's start/end/counter and in-flight inputs, so it closes the loop opposite the controller.

---
 rtl/riscv_hwloop_regfile_if.sv | 31 +++
 rtl/riscv_hwloop_regfile.sv | 65 ++++++
 2 files changed

// File: rtl/riscv_hwloop_regfile_if.sv
// Setup-write, in-flight and register-readout signals between the ID stage/controller and the hwloop register bank.
interface riscv_hwloop_regfile_if #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
);
  logic [31:0]                   hwlp_start_data_i;
  logic [31:0]                   hwlp_end_data_i;
  logic [31:0]                   hwlp_cnt_data_i;
  logic [2:0]                    hwlp_we_i;
  logic [N_REG_BITS-1:0]         hwlp_regid_i;
  logic [N_REGS-1:0]             hwlp_dec_cnt_i;
  logic                          if_valid_i;
  logic                          id_valid_i;
  logic                          clear_i;
  logic [N_REGS-1:0][31:0]       hwlp_start_addr_o;
  logic [N_REGS-1:0][31:0]       hwlp_end_addr_o;
  logic [N_REGS-1:0][31:0]       hwlp_counter_o;
  logic [N_REGS-1:0]             hwlp_dec_cnt_id_o;

  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i, hwlp_regid_i,
           hwlp_dec_cnt_i, if_valid_i, id_valid_i, clear_i,
    input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
  );

  modport slave (
    input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i, hwlp_regid_i,
           hwlp_dec_cnt_i, if_valid_i, id_valid_i, clear_i,
    output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
  );
endinterface

// File: rtl/riscv_hwloop_regfile.sv
// Hardware-loop start/end/counter bank with IF->ID decrement bookkeeping.
// Writes visible one cycle later; decrements apply the cycle after the marked instruction leaves ID; no backpressure.
module riscv_hwloop_regfile #(
  parameter int N_REGS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_hwloop_regfile_if.slave hw
);

  logic [N_REGS-1:0][31:0] start_q, start_d;
  logic [N_REGS-1:0][31:0] end_q,   end_d;
  logic [N_REGS-1:0][31:0] cnt_q,   cnt_d;
  logic [N_REGS-1:0]       pend_q,  pend_d;
  logic [N_REGS-1:0]       sel;
  logic [N_REGS-1:0]       cnt_we;
  logic [N_REGS-1:0]       dec_en;

  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sel     = '0;
    cnt_we  = '0;
    dec_en  = '0;
    for (int k = 0; k < N_REGS; k++) begin
      // Out-of-range regids match no loop, so such writes fall through.
      sel[k]    = (32'(hw.hwlp_regid_i) == k);
      cnt_we[k] = hw.hwlp_we_i[2] & sel[k];
      dec_en[k] = hw.id_valid_i & pend_q[k] & ~hw.clear_i & ~cnt_we[k];

      if (hw.hwlp_we_i[0] && sel[k]) start_d[k] = hw.hwlp_start_data_i;
      if (hw.hwlp_we_i[1] && sel[k]) end_d[k]   = hw.hwlp_end_data_i;

      if (cnt_we[k])                         cnt_d[k] = hw.hwlp_cnt_data_i;
      else if (dec_en[k] && cnt_q[k] != '0)  cnt_d[k] = cnt_q[k] - 32'd1;

      if (cnt_we[k])            pend_d[k] = 1'b0;
      else if (hw.clear_i)      pend_d[k] = hw.if_valid_i & hw.hwlp_dec_cnt_i[k];
      else if (hw.if_valid_i)   pend_d[k] = hw.hwlp_dec_cnt_i[k];
      else if (hw.id_valid_i)   pend_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign hw.hwlp_start_addr_o = start_q;
  assign hw.hwlp_end_addr_o   = end_q;
  assign hw.hwlp_counter_o    = cnt_q;
  assign hw.hwlp_dec_cnt_id_o = pend_q;

endmodule
